// File: rtl/clint_timer.sv
// ---------------------------------------------------------------------------
// clint_timer
//
// Core-local interruptor slave for the CLINT window. Holds the 64-bit mtime
// counter (advanced by an RTC tick divided down from the core clock), the
// 64-bit mtimecmp compare register and the msip software-interrupt bit, and
// drives the machine timer / software interrupt lines to the core.
//
// Ports:
//   clock        in   1   core clock
//   reset        in   1   asynchronous active-high reset
//   clint_valid  in   1   request valid, held until clint_ready
//   clint_addr   in  32   byte address (word aligned)
//   clint_wdata  in  32   write data
//   clint_wstrb  in   4   byte write enables, all-zero means read
//   clint_rdata  out 32   read data, valid while clint_ready is high
//   clint_ready  out  1   one-cycle completion pulse
//   clint_msip   out  1   machine software interrupt
//   clint_mtip   out  1   machine timer interrupt (registered compare)
//   clint_mtime  out 64   current mtime, exported for the time CSR
// ---------------------------------------------------------------------------
module clint_timer #(
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter int unsigned clk_divider_rtc = 49
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam int unsigned DIV_W = (clk_divider_rtc < 1) ? 1 : $clog2(clk_divider_rtc + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_divider_rtc);

    localparam logic [31:0] OFF_MSIP     = 32'h0000_0000;
    localparam logic [31:0] OFF_CMP_LO   = 32'h0000_4000;
    localparam logic [31:0] OFF_CMP_HI   = 32'h0000_4004;
    localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
    localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [63:0]      r_mtime;
    logic [63:0]      r_mtimecmp;
    logic             r_msip;
    logic             r_mtip;
    logic [31:0]      r_rdata;
    logic [DIV_W-1:0] r_divCount;
    logic             r_rtcPhase;

    logic [31:0]      w_offset;
    logic [31:0]      w_readData;
    logic             w_accept;
    logic             w_isWrite;
    logic             w_tick;
    logic             w_wrMsip;
    logic             w_wrCmpLo;
    logic             w_wrCmpHi;
    logic             w_wrTimeLo;
    logic             w_wrTimeHi;

    // Replace only the strobed bytes of a 32-bit word.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = newVal[8*i +: 8];
            end
        end
        return result;
    endfunction

    assign w_offset   = clint_addr - clint_base_addr;
    assign w_accept   = (r_state == IDLE) && clint_valid;
    assign w_isWrite  = |clint_wstrb;
    assign w_wrMsip   = w_accept && w_isWrite && (w_offset == OFF_MSIP);
    assign w_wrCmpLo  = w_accept && w_isWrite && (w_offset == OFF_CMP_LO);
    assign w_wrCmpHi  = w_accept && w_isWrite && (w_offset == OFF_CMP_HI);
    assign w_wrTimeLo = w_accept && w_isWrite && (w_offset == OFF_MTIME_LO);
    assign w_wrTimeHi = w_accept && w_isWrite && (w_offset == OFF_MTIME_HI);

    // The tick fires on the edge where the RTC phase goes from low to high.
    assign w_tick = (r_divCount == DIV_LAST) && !r_rtcPhase;

    // Read data is captured from the register values at acceptance.
    always_comb begin
        w_readData = '0;
        case (w_offset)
            OFF_MSIP:     w_readData = {31'b0, r_msip};
            OFF_CMP_LO:   w_readData = r_mtimecmp[31:0];
            OFF_CMP_HI:   w_readData = r_mtimecmp[63:32];
            OFF_MTIME_LO: w_readData = r_mtime[31:0];
            OFF_MTIME_HI: w_readData = r_mtime[63:32];
            default:      w_readData = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // RESP lasts exactly one cycle and ignores clint_valid.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (clint_valid) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= (w_accept && !w_isWrite) ? w_readData : 32'h0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= '1;
        end else begin
            if (w_wrMsip && clint_wstrb[0]) begin
                r_msip <= clint_wdata[0];
            end
            if (w_wrCmpLo) begin
                r_mtimecmp[31:0] <= mergeBytes(r_mtimecmp[31:0], clint_wdata, clint_wstrb);
            end
            if (w_wrCmpHi) begin
                r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], clint_wdata, clint_wstrb);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_divCount <= '0;
            r_rtcPhase <= 1'b0;
        end else if (r_divCount == DIV_LAST) begin
            r_divCount <= '0;
            r_rtcPhase <= ~r_rtcPhase;
        end else begin
            r_divCount <= r_divCount + DIV_W'(1);
        end
    end

    // A software write to either mtime half suppresses that cycle's tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mtime <= '0;
        end else if (w_wrTimeLo || w_wrTimeHi) begin
            if (w_wrTimeLo) begin
                r_mtime[31:0] <= mergeBytes(r_mtime[31:0], clint_wdata, clint_wstrb);
            end
            if (w_wrTimeHi) begin
                r_mtime[63:32] <= mergeBytes(r_mtime[63:32], clint_wdata, clint_wstrb);
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    assign clint_ready = (r_state == RESP);
    assign clint_rdata = r_rdata;
    assign clint_msip  = r_msip;
    assign clint_mtip  = r_mtip;
    assign clint_mtime = r_mtime;

endmodule
